ultrasonic_echo_responder: RTL
==============================

Name: ultrasonic_echo_responder

Overview:
Emulates the sensor end of the HC-SR04 trig/echo protocol. It accepts a trig pulse from a ranging controller and, after a fixed burst delay, drives an echo pulse. The echo width is distance_cm × US_PER_CM µs. It is used as an on-FPGA stand-in sensor for bring-up and as a synthesizable bench model for the ranging controller.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency; TPU = CLK_FREQ_HZ/1_000_000 clocks per µs
US_PER_CM, 58, echo µs per cm
MIN_TRIG_US, 10, minimum valid trig high width in µs
BURST_US, 200, delay from accepted trig fall to echo rise (8×40 kHz burst)
MAX_ECHO_US, 38000, echo width for no object or clamp
HOLDOFF_US, 1000, dead time after echo fall; trig is ignored during it
DIST_W, 9, distance input width

Ports:
clk  in  1  system clock
reset_p  in  1  asynchronous active-high reset
trig  in  1  trigger from controller, asynchronous
distance_cm  in  DIST_W  emulated target distance
range_valid  in  1  1 = object present; 0 = no echo return
echo  out  1  echo pulse to controller
busy  out  1  high in any state except S_IDLE and S_TRIG_HIGH
short_trig  out  1  one-clock pulse when trig is rejected as too short
trig_count  out  8  accepted trigger count, wraps at 255→0

Behaviour:
- Reset values: echo=0, busy=0, short_trig=0, trig_count=0, state=S_IDLE, all counters=0.
- trig passes through a 2-flop synchronizer and then a rising/falling edge detector. Edges are detected 3 clocks after the pin changes.
- The µs tick comes from a prescaler of period TPU. The prescaler restarts at 0 on every state transition, so every timed interval equals N×TPU clocks exactly.
- One-hot states:
  - S_IDLE: on trig rising edge → S_TRIG_HIGH, clear us_cnt.
  - S_TRIG_HIGH: us_cnt counts µs while trig is high. On trig falling edge:
    - us_cnt ≥ MIN_TRIG_US → latch width, trig_count+1 → S_BURST.
    - Otherwise → pulse short_trig → S_IDLE.
  - S_BURST: after BURST_US ticks → echo=1 → S_ECHO.
  - S_ECHO: after echo_width ticks → echo=0 → S_HOLDOFF.
  - S_HOLDOFF: after HOLDOFF_US ticks → S_IDLE.
  - Illegal state code → S_IDLE.
- Width latch happens at the trig falling-edge cycle:
  - echo_width = max(distance_cm,1) × US_PER_CM.
  - If range_valid=0 or product > MAX_ECHO_US, echo_width = MAX_ECHO_US.
  - distance_cm=0 is treated as 1 cm (58 µs).
  - The product is computed at 16 bits; us_cnt is 16 bits.
- Changes to distance_cm or range_valid after the latch do not affect the pulse in flight.
- Trig edges in S_BURST, S_ECHO and S_HOLDOFF are ignored and not counted.
- A trig rising edge in the same cycle as the S_HOLDOFF→S_IDLE transition is ignored; the next rising edge is required.
- Timing: echo rises exactly BURST_US×TPU clocks after the falling-edge detection cycle, and stays high exactly echo_width×TPU clocks.
- Reset mid-operation: echo drops to 0 asynchronously and the state returns to S_IDLE.

Optional Feature:
ULTRASONIC_ECHO_JITTER_EN
- Defined: a 16-bit LFSR (seed 16'hACE1, advanced once per accepted trig) adds its low 3 bits, 0..7 µs, to echo_width after the clamp. The total never exceeds MAX_ECHO_US.
- Undefined: the LFSR is absent and echo_width is exact.

Decomposition:
- Package ultrasonic_pkg holds:
  - state encodings S_IDLE, S_TRIG_HIGH, S_BURST, S_ECHO, S_HOLDOFF;
  - US_PER_CM, MIN_TRIG_US, BURST_US, MAX_ECHO_US defaults;
  - the LFSR seed.
- One sub-module: usec_tick_gen (inputs clk, reset_p, restart; output tick), a prescaler of period TPU.
- The edge detector reuses the existing codebase edge_detector_n.

Test Plan:
- distance_cm=10, range_valid=1, trig high 12 µs → echo rises 20000 clocks after detection, width 58000 clocks; trig_count=1, short_trig never asserted.
- trig high 5 µs → short_trig pulses exactly one clock, echo stays 0, trig_count unchanged, busy stays 0.
- range_valid=0, trig 10 µs → echo width 3_800_000 clocks (38000 µs).
- distance_cm=0 → echo width 5800 clocks; distance_cm=511 → echo width 2_963_800 clocks.
- Second trig during S_ECHO, and again 500 µs into S_HOLDOFF → both ignored, trig_count unchanged; trig after holdoff is accepted.
- reset_p asserted 100 µs into S_ECHO → echo=0 in the same cycle; after release, 255 valid trigs → trig_count wraps to 0 on the 256th.

Source files
------------

// File: rtl/ultrasonic_echo_responder_pkg.sv
// Shared state encodings, timing defaults and LFSR helpers for the
// ultrasonic echo responder.
package ultrasonic_pkg;

  typedef enum logic [4:0] {
    S_IDLE      = 5'b00001,
    S_TRIG_HIGH = 5'b00010,
    S_BURST     = 5'b00100,
    S_ECHO      = 5'b01000,
    S_HOLDOFF   = 5'b10000
  } state_t;

  localparam int US_PER_CM_DEF   = 58;
  localparam int MIN_TRIG_US_DEF = 10;
  localparam int BURST_US_DEF    = 200;
  localparam int MAX_ECHO_US_DEF = 38000;
  localparam int HOLDOFF_US_DEF  = 1000;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // x^16 + x^14 + x^13 + x^11 Fibonacci LFSR
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

endpackage

// File: rtl/ultrasonic_echo_responder_if.sv
// trig/echo bundle between a ranging controller (master) and the
// emulated sensor (slave).
interface ultrasonic_echo_responder_if #(
  parameter int DIST_W = 9
);
  logic              trig;
  logic [DIST_W-1:0] distance_cm;
  logic              range_valid;
  logic              echo;
  logic              busy;
  logic              short_trig;
  logic [7:0]        trig_count;

  modport master (
    output trig, distance_cm, range_valid,
    input  echo, busy, short_trig, trig_count
  );

  modport slave (
    input  trig, distance_cm, range_valid,
    output echo, busy, short_trig, trig_count
  );
endinterface

// File: rtl/edge_detector_n.sv
// Registered rising/falling edge detector for an already
// synchronized level.
module edge_detector_n (
  input  logic clk,
  input  logic reset_p,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic prev_q;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      prev_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      prev_q <= din;
      rise   <= din & ~prev_q;
      fall   <= ~din & prev_q;
    end
  end
endmodule

// File: rtl/ultrasonic_echo_responder_usec_tick_gen.sv
// Microsecond prescaler of period TPU clocks; restart realigns the
// phase so intervals start exactly at a state change.
module usec_tick_gen #(
  parameter int TPU = 100
) (
  input  logic clk,
  input  logic reset_p,
  input  logic restart,
  output logic tick
);
  localparam int CW = (TPU > 1) ? $clog2(TPU) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(TPU - 1));

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)
      cnt_q <= '0;
    else if (restart || tick)
      cnt_q <= '0;
    else
      cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/ultrasonic_echo_responder.sv
// HC-SR04 style trig/echo sensor emulator.
// Optional echo jitter: define ULTRASONIC_ECHO_JITTER_EN.
module ultrasonic_echo_responder
  import ultrasonic_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int US_PER_CM   = US_PER_CM_DEF,
  parameter int MIN_TRIG_US = MIN_TRIG_US_DEF,
  parameter int BURST_US    = BURST_US_DEF,
  parameter int MAX_ECHO_US = MAX_ECHO_US_DEF,
  parameter int HOLDOFF_US  = HOLDOFF_US_DEF,
  parameter int DIST_W      = 9
) (
  input logic clk,
  input logic reset_p,
  ultrasonic_echo_responder_if.slave bus
);
  localparam int TPU = CLK_FREQ_HZ / 1_000_000;
  localparam logic [15:0] MAX16 = 16'(MAX_ECHO_US);

  state_t      state_q, state_d;
  logic [15:0] us_q, us_d;
  logic [15:0] width_q, width_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        echo_q, echo_d;
  logic        short_q, short_d;
  logic        sync1_q, sync2_q;
  logic        trig_rise, trig_fall;
  logic        tick, restart;
  logic [15:0] dist_eff, prod, base_w, width_new;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.trig;
      sync2_q <= sync1_q;
    end
  end

  edge_detector_n u_edge (
    .clk     (clk),
    .reset_p (reset_p),
    .din     (sync2_q),
    .rise    (trig_rise),
    .fall    (trig_fall)
  );

  usec_tick_gen #(.TPU(TPU)) u_tick (
    .clk     (clk),
    .reset_p (reset_p),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    dist_eff = 16'(bus.distance_cm);
    if (dist_eff == 16'd0)
      dist_eff = 16'd1;
    prod = dist_eff * 16'(US_PER_CM);
    if (!bus.range_valid || prod > MAX16)
      base_w = MAX16;
    else
      base_w = prod;
  end

`ifdef ULTRASONIC_ECHO_JITTER_EN
  logic [15:0] lfsr_q;
  logic [16:0] jsum;

  always_comb begin
    jsum = {1'b0, base_w} + {14'd0, lfsr_q[2:0]};
    if (jsum > {1'b0, MAX16})
      width_new = MAX16;
    else
      width_new = jsum[15:0];
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)
      lfsr_q <= LFSR_SEED;
    else if (state_q == S_TRIG_HIGH && state_d == S_BURST)
      lfsr_q <= lfsr_next(lfsr_q);
  end
`else
  assign width_new = base_w;
`endif

  always_comb begin
    state_d = state_q;
    width_d = width_q;
    cnt_d   = cnt_q;
    echo_d  = echo_q;
    short_d = 1'b0;
    us_d    = us_q;
    if (tick && us_q != 16'hFFFF)
      us_d = us_q + 16'd1;
    case (state_q)
      S_IDLE: begin
        if (trig_rise)
          state_d = S_TRIG_HIGH;
      end
      S_TRIG_HIGH: begin
        // a tick landing on the fall cycle still counts toward the width
        if (trig_fall) begin
          if (({1'b0, us_q} + {16'd0, tick}) >= 17'(MIN_TRIG_US)) begin
            width_d = width_new;
            cnt_d   = cnt_q + 8'd1;
            state_d = S_BURST;
          end else begin
            short_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_BURST: begin
        if (tick && us_q == 16'(BURST_US - 1)) begin
          echo_d  = 1'b1;
          state_d = S_ECHO;
        end
      end
      S_ECHO: begin
        if (tick && us_q == width_q - 16'd1) begin
          echo_d  = 1'b0;
          state_d = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (tick && us_q == 16'(HOLDOFF_US - 1))
          state_d = S_IDLE;
      end
      default: begin
        echo_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    restart = (state_d != state_q);
    if (restart)
      us_d = 16'd0;
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q <= S_IDLE;
      us_q    <= 16'd0;
      width_q <= 16'd0;
      cnt_q   <= 8'd0;
      echo_q  <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      us_q    <= us_d;
      width_q <= width_d;
      cnt_q   <= cnt_d;
      echo_q  <= echo_d;
      short_q <= short_d;
    end
  end

  assign bus.echo       = echo_q;
  assign bus.short_trig = short_q;
  assign bus.trig_count = cnt_q;
  assign bus.busy       = !(state_q == S_IDLE || state_q == S_TRIG_HIGH);
endmodule
